rvc_asap_5pl_cr_arb: RTL and testbench

Arbiter that shares the single CR_MEM access port between the 5-stage core's memory stage and a debug/host bridge requester. The core has priority by default. A bounded-wait counter guarantees debug progress by stalling the core for one cycle. The block sits between the core's CR access signals and the CR_MEM instance, and routes CR_MEM's one-cycle-latency read data back to the requester that issued the read.

---
 rtl/rvc_asap_5pl_cr_arb_if.sv | 44 ++++
 rtl/rvc_asap_5pl_cr_arb.sv | 130 +++++++++++++
 tb/tb_rvc_asap_5pl_cr_arb.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rvc_asap_5pl_cr_arb_if.sv
// Bundle of the core, debug-bridge and CR_MEM signals seen by the CR port arbiter.
// slave  : the arbiter view.
// master : the surrounding core, debug bridge and CR_MEM view.
interface rvc_asap_5pl_cr_arb_if;
    // core memory-stage side
    logic        core_rden;
    logic        core_wren;
    logic [31:0] core_address;
    logic [31:0] core_data;
    logic [31:0] core_q;
    logic        core_stall;
    // debug / host bridge side
    logic        dbg_req_valid;
    logic        dbg_req_ready;
    logic        dbg_wr;
    logic [31:0] dbg_address;
    logic [31:0] dbg_data;
    logic        dbg_rsp_valid;
    logic [31:0] dbg_rdata;
    // CR_MEM side
    logic        mem_rden;
    logic        mem_wren;
    logic [31:0] mem_address;
    logic [31:0] mem_data;
    logic [31:0] mem_q;

    modport slave (
        input  core_rden, core_wren, core_address, core_data,
        output core_q, core_stall,
        input  dbg_req_valid, dbg_wr, dbg_address, dbg_data,
        output dbg_req_ready, dbg_rsp_valid, dbg_rdata,
        output mem_rden, mem_wren, mem_address, mem_data,
        input  mem_q
    );

    modport master (
        output core_rden, core_wren, core_address, core_data,
        input  core_q, core_stall,
        output dbg_req_valid, dbg_wr, dbg_address, dbg_data,
        input  dbg_req_ready, dbg_rsp_valid, dbg_rdata,
        input  mem_rden, mem_wren, mem_address, mem_data,
        output mem_q
    );
endinterface

// File: rtl/rvc_asap_5pl_cr_arb.sv
// CR_MEM port arbiter between the core memory stage and a debug/host bridge.
// The core owns the port by default; a pending debug request takes the first
// core-idle cycle, or forces a single-cycle core stall once it has waited
// MAX_WAIT core-busy cycles. CR_MEM read data is steered back to whoever
// issued the read one cycle earlier.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | ready for a debug request; accepted request is captured, not issued
// WAIT  | captured request waiting for the port; wait_cnt counts busy cycles
// RESP  | one-cycle response pulse; read data comes straight from mem_q
module rvc_asap_5pl_cr_arb #(
    parameter int unsigned MAX_WAIT = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    rvc_asap_5pl_cr_arb_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    state_t            state, state_nxt;
    owner_t            rd_owner, rd_owner_nxt;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
    logic              cap_wr, cap_wr_nxt;
    logic [31:0]       cap_address, cap_address_nxt;
    logic [31:0]       cap_data, cap_data_nxt;

    logic              core_req;
    logic              dbg_grant;
    logic              req_ready;
    logic              rsp_valid;
    logic              stall;

    assign core_req = bus.core_rden | bus.core_wren;

    // Registered arbiter state: FSM, wait counter, read owner and captured request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            rd_owner    <= OWN_NONE;
            wait_cnt    <= '0;
            cap_wr      <= 1'b0;
            cap_address <= '0;
            cap_data    <= '0;
        end else begin
            state       <= state_nxt;
            rd_owner    <= rd_owner_nxt;
            wait_cnt    <= wait_cnt_nxt;
            cap_wr      <= cap_wr_nxt;
            cap_address <= cap_address_nxt;
            cap_data    <= cap_data_nxt;
        end
    end

    // Next-state, grant decision, wait counting and read-owner tracking.
    always_comb begin
        state_nxt       = state;
        wait_cnt_nxt    = wait_cnt;
        cap_wr_nxt      = cap_wr;
        cap_address_nxt = cap_address;
        cap_data_nxt    = cap_data;
        dbg_grant       = 1'b0;
        req_ready       = 1'b0;
        rsp_valid       = 1'b0;
        stall           = 1'b0;

        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (bus.dbg_req_valid) begin
                    cap_wr_nxt      = bus.dbg_wr;
                    cap_address_nxt = bus.dbg_address;
                    cap_data_nxt    = bus.dbg_data;
                    wait_cnt_nxt    = '0;
                    state_nxt       = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!core_req || (wait_cnt == MAX_CNT)) begin
                    dbg_grant = 1'b1;
                    stall     = core_req;
                    state_nxt = ST_RESP;
                end else begin
                    // Grant is forced at MAX_CNT, so this never passes it.
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // A stalled core access is not issued, so only the debug read can own the data.
        if (dbg_grant) begin
            rd_owner_nxt = cap_wr ? OWN_NONE : OWN_DBG;
        end else begin
            rd_owner_nxt = bus.core_rden ? OWN_CORE : OWN_NONE;
        end
    end

    assign bus.mem_rden    = dbg_grant ? ~cap_wr     : bus.core_rden;
    assign bus.mem_wren    = dbg_grant ?  cap_wr     : bus.core_wren;
    assign bus.mem_address = dbg_grant ?  cap_address : bus.core_address;
    assign bus.mem_data    = dbg_grant ?  cap_data    : bus.core_data;

    assign bus.core_stall    = stall;
    assign bus.core_q        = (rd_owner == OWN_CORE) ? bus.mem_q : 32'h0;
    assign bus.dbg_req_ready = req_ready;
    assign bus.dbg_rsp_valid = rsp_valid;
    assign bus.dbg_rdata     = (rsp_valid && !cap_wr) ? bus.mem_q : 32'h0;

endmodule

// File: tb/tb_rvc_asap_5pl_cr_arb.sv
// Bench for the CR port arbiter: directed scenarios with literal expectations,
// then random core/debug traffic compared every cycle against a
// transaction-level model that tracks CR contents on its own.
module tb_rvc_asap_5pl_cr_arb;

    localparam int MAX_WAIT = 4;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    rvc_asap_5pl_cr_arb_if bus ();

    rvc_asap_5pl_cr_arb #(.MAX_WAIT(MAX_WAIT), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // CR_MEM stand-in: registered read, read returns the pre-write contents.
    logic [31:0] cr_mem [16];
    always @(posedge clk) begin
        if (bus.mem_wren) cr_mem[bus.mem_address[3:0]] <= bus.mem_data;
        if (bus.mem_rden) bus.mem_q <= cr_mem[bus.mem_address[3:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding debug transaction plus expected CR contents.
    logic [31:0] ref_mem [16];
    logic        m_pend, m_wr;
    logic [31:0] m_addr, m_data;
    int          m_busy;
    logic        m_rsp_due;
    logic [31:0] m_rsp_data;
    logic        m_core_due;
    logic [31:0] m_core_data;

    // Per-cycle compare of every DUT output against the model, then advance the model.
    always @(negedge clk) begin
        logic        core_req, issue, exp_ready;
        logic [31:0] rd_old;
        if (rst) begin
            m_pend     = 1'b0;
            m_busy     = 0;
            m_rsp_due  = 1'b0;
            m_core_due = 1'b0;
        end else begin
            core_req  = bus.core_rden | bus.core_wren;
            issue     = m_pend && (!core_req || m_busy == MAX_WAIT);
            exp_ready = !m_pend && !m_rsp_due;

            chk("mdl_ready", {31'h0, bus.dbg_req_ready}, {31'h0, exp_ready});
            chk("mdl_stall", {31'h0, bus.core_stall}, {31'h0, issue && core_req});
            chk("mdl_rsp_valid", {31'h0, bus.dbg_rsp_valid}, {31'h0, m_rsp_due});
            chk("mdl_rdata", bus.dbg_rdata, m_rsp_due ? m_rsp_data : 32'h0);
            chk("mdl_core_q", bus.core_q, m_core_due ? m_core_data : 32'h0);
            if (issue) begin
                chk("mdl_mem_rden", {31'h0, bus.mem_rden}, {31'h0, !m_wr});
                chk("mdl_mem_wren", {31'h0, bus.mem_wren}, {31'h0, m_wr});
                chk("mdl_mem_addr", bus.mem_address, m_addr);
                chk("mdl_mem_data", bus.mem_data, m_data);
            end else begin
                chk("mdl_mem_rden", {31'h0, bus.mem_rden}, {31'h0, bus.core_rden});
                chk("mdl_mem_wren", {31'h0, bus.mem_wren}, {31'h0, bus.core_wren});
                chk("mdl_mem_addr", bus.mem_address, bus.core_address);
                chk("mdl_mem_data", bus.mem_data, bus.core_data);
            end

            m_rsp_due  = issue;
            m_core_due = !issue && bus.core_rden;
            if (issue) begin
                rd_old     = ref_mem[m_addr[3:0]];
                m_rsp_data = m_wr ? 32'h0 : rd_old;
                if (m_wr) ref_mem[m_addr[3:0]] = m_data;
                m_pend = 1'b0;
            end else begin
                rd_old = ref_mem[bus.core_address[3:0]];
                if (bus.core_rden) m_core_data = rd_old;
                if (bus.core_wren) ref_mem[bus.core_address[3:0]] = bus.core_data;
                if (m_pend && m_busy < MAX_WAIT) m_busy++;
            end
            if (exp_ready && bus.dbg_req_valid) begin
                m_pend = 1'b1;
                m_busy = 0;
                m_wr   = bus.dbg_wr;
                m_addr = bus.dbg_address;
                m_data = bus.dbg_data;
            end
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic core_idle();
        bus.core_rden    = 1'b0;
        bus.core_wren    = 1'b0;
        bus.core_address = 32'h0;
        bus.core_data    = 32'h0;
    endtask

    task automatic dbg_set(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
        bus.dbg_req_valid = v;
        bus.dbg_wr        = w;
        bus.dbg_address   = a;
        bus.dbg_data      = d;
    endtask

    logic        core_hold, dbg_hold;
    logic [2:0]  r;

    initial begin
        rst = 1'b1;
        core_idle();
        dbg_set(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 16; i++) begin
            cr_mem[i]  = 32'h100 + i;
            ref_mem[i] = 32'h100 + i;
        end
        cr_mem[7] = 32'h3F;   ref_mem[7] = 32'h3F;     // CR_SEG7_0
        cr_mem[2] = 32'h0;    ref_mem[2] = 32'h0;      // CR_LED
        cr_mem[3] = 32'hA5A5; ref_mem[3] = 32'hA5A5;
        cr_mem[9] = 32'h99;   ref_mem[9] = 32'h99;

        // reset state, mem_* pass the core through
        bus.core_rden    = 1'b1;
        bus.core_address = 32'h5;
        to_neg();
        chk("rst_ready", {31'h0, bus.dbg_req_ready}, 32'h1);
        chk("rst_rsp_valid", {31'h0, bus.dbg_rsp_valid}, 32'h0);
        chk("rst_rdata", bus.dbg_rdata, 32'h0);
        chk("rst_stall", {31'h0, bus.core_stall}, 32'h0);
        chk("rst_core_q", bus.core_q, 32'h0);
        chk("rst_mem_rden", {31'h0, bus.mem_rden}, 32'h1);
        chk("rst_mem_addr", bus.mem_address, 32'h5);
        core_idle();
        drive_edge();
        drive_edge();
        rst = 1'b0;

        // idle core, debug read of CR_SEG7_0
        drive_edge(); dbg_set(1'b1, 1'b0, 32'h7, 32'h0);
        to_neg(); chk("t1_ready_T", {31'h0, bus.dbg_req_ready}, 32'h1);
        drive_edge(); dbg_set(1'b0, 1'b0, 32'h0, 32'h0);
        to_neg();
        chk("t1_mem_rden", {31'h0, bus.mem_rden}, 32'h1);
        chk("t1_mem_addr", bus.mem_address, 32'h7);
        chk("t1_stall", {31'h0, bus.core_stall}, 32'h0);
        drive_edge(); to_neg();
        chk("t1_rsp_valid", {31'h0, bus.dbg_rsp_valid}, 32'h1);
        chk("t1_rdata", bus.dbg_rdata, 32'h3F);

        // core reads CR_LED every cycle, debug write 0x155 waits MAX_WAIT cycles
        drive_edge();
        bus.core_rden = 1'b1; bus.core_address = 32'h2;
        dbg_set(1'b1, 1'b1, 32'h2, 32'h155);
        to_neg(); chk("t2_ready_T", {31'h0, bus.dbg_req_ready}, 32'h1);
        for (int k = 1; k <= 7; k++) begin
            drive_edge();
            if (k == 1) dbg_set(1'b0, 1'b0, 32'h0, 32'h0);
            to_neg();
            if (k < 5) chk("t2_stall_low", {31'h0, bus.core_stall}, 32'h0);
            if (k == 5) begin
                chk("t2_stall_high", {31'h0, bus.core_stall}, 32'h1);
                chk("t2_mem_wren", {31'h0, bus.mem_wren}, 32'h1);
                chk("t2_mem_data", bus.mem_data, 32'h155);
            end
            if (k == 6) begin
                chk("t2_rsp_valid", {31'h0, bus.dbg_rsp_valid}, 32'h1);
                chk("t2_rdata", bus.dbg_rdata, 32'h0);
                chk("t2_stall_after", {31'h0, bus.core_stall}, 32'h0);
                chk("t2_core_q_none", bus.core_q, 32'h0);
            end
            if (k == 7) chk("t2_core_readback", bus.core_q, 32'h155);
        end

        // core read at N, debug granted at N+1: read data routing
        drive_edge(); core_idle(); dbg_set(1'b1, 1'b0, 32'h7, 32'h0);
        to_neg();
        drive_edge(); dbg_set(1'b0, 1'b0, 32'h0, 32'h0);
        bus.core_rden = 1'b1; bus.core_address = 32'h3;
        to_neg(); chk("t3_core_issue", bus.mem_address, 32'h3);
        drive_edge(); core_idle();
        to_neg();
        chk("t3_dbg_issue", bus.mem_address, 32'h7);
        chk("t3_core_q", bus.core_q, 32'hA5A5);
        drive_edge(); to_neg();
        chk("t3_core_q_zero", bus.core_q, 32'h0);
        chk("t3_rdata", bus.dbg_rdata, 32'h3F);

        // core busy two cycles then idle: grant in first idle cycle, no stall
        drive_edge(); dbg_set(1'b1, 1'b0, 32'h7, 32'h0);
        to_neg();
        drive_edge(); dbg_set(1'b0, 1'b0, 32'h0, 32'h0);
        bus.core_rden = 1'b1; bus.core_address = 32'h3;
        to_neg(); chk("t4_stall_1", {31'h0, bus.core_stall}, 32'h0);
        drive_edge();
        to_neg(); chk("t4_stall_2", {31'h0, bus.core_stall}, 32'h0);
        drive_edge(); core_idle();
        to_neg();
        chk("t4_stall_3", {31'h0, bus.core_stall}, 32'h0);
        chk("t4_grant_addr", bus.mem_address, 32'h7);
        drive_edge(); to_neg();
        chk("t4_rdata", bus.dbg_rdata, 32'h3F);

        // reset while a debug write waits: dropped, CR untouched
        drive_edge(); dbg_set(1'b1, 1'b1, 32'h9, 32'hDEAD);
        bus.core_rden = 1'b1; bus.core_address = 32'h3;
        to_neg();
        drive_edge(); dbg_set(1'b0, 1'b0, 32'h0, 32'h0);
        to_neg(); chk("t5_wait_ready", {31'h0, bus.dbg_req_ready}, 32'h0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_ready", {31'h0, bus.dbg_req_ready}, 32'h1);
        chk("t5_rst_rsp", {31'h0, bus.dbg_rsp_valid}, 32'h0);
        core_idle();
        drive_edge();
        drive_edge(); rst = 1'b0;
        drive_edge(); dbg_set(1'b1, 1'b0, 32'h9, 32'h0);
        to_neg();
        drive_edge(); dbg_set(1'b0, 1'b0, 32'h0, 32'h0);
        to_neg(); chk("t5_no_wren", {31'h0, bus.mem_wren}, 32'h0);
        drive_edge(); to_neg();
        chk("t5_rdata_kept", bus.dbg_rdata, 32'h99);

        // back-to-back debug reads with valid held high
        drive_edge(); dbg_set(1'b1, 1'b0, 32'h7, 32'h0);
        to_neg(); chk("t6_ready_T0", {31'h0, bus.dbg_req_ready}, 32'h1);
        drive_edge(); bus.dbg_address = 32'h3;
        to_neg(); chk("t6_ready_T1", {31'h0, bus.dbg_req_ready}, 32'h0);
        drive_edge(); to_neg();
        chk("t6_ready_T2", {31'h0, bus.dbg_req_ready}, 32'h0);
        chk("t6_rsp_T2", {31'h0, bus.dbg_rsp_valid}, 32'h1);
        chk("t6_rdata_T2", bus.dbg_rdata, 32'h3F);
        drive_edge(); to_neg();
        chk("t6_ready_T3", {31'h0, bus.dbg_req_ready}, 32'h1);
        drive_edge(); dbg_set(1'b0, 1'b0, 32'h0, 32'h0);
        to_neg(); chk("t6_ready_T4", {31'h0, bus.dbg_req_ready}, 32'h0);
        drive_edge(); to_neg();
        chk("t6_rsp_T5", {31'h0, bus.dbg_rsp_valid}, 32'h1);
        chk("t6_rdata_T5", bus.dbg_rdata, 32'hA5A5);

        // random traffic: core retries stalled accesses, debug holds until accepted
        core_hold = 1'b0;
        dbg_hold  = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            drive_edge();
            if (!core_hold) begin
                r = 3'($urandom);
                bus.core_rden    = r[0];
                bus.core_wren    = r[1] & r[2];
                bus.core_address = 32'($urandom_range(0, 15));
                bus.core_data    = $urandom;
            end
            if (!dbg_hold) begin
                bus.dbg_req_valid = ($urandom_range(0, 2) == 0);
                bus.dbg_wr        = 1'($urandom_range(0, 1));
                bus.dbg_address   = 32'($urandom_range(0, 15));
                bus.dbg_data      = $urandom;
            end
            to_neg();
            core_hold = bus.core_stall;
            dbg_hold  = bus.dbg_req_valid & ~bus.dbg_req_ready;
        end

        drive_edge();
        core_idle();
        dbg_set(1'b0, 1'b0, 32'h0, 32'h0);
        drive_edge();
        drive_edge();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
